// File: rtl/line_pkg.sv
// line_pkg: shared types for the line command scheduler.
package line_pkg;
    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int COL_W = 3;

    typedef struct packed {
        logic [COL_W-1:0] colour;
        logic [X_W-1:0]   x0;
        logic [Y_W-1:0]   y0;
        logic [X_W-1:0]   x1;
        logic [Y_W-1:0]   y1;
    } line_cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_GO, S_GAP} state_t;
endpackage

// File: rtl/line_cmd_fifo.sv
// line_cmd_fifo: small circular FIFO of line commands with occupancy count and flush.
module line_cmd_fifo
    import line_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  line_cmd_t              wdata,
    output line_cmd_t              rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    line_cmd_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/line_cmd_scheduler.sv
// line_cmd_scheduler: round-robin arbitration of two command sources into a FIFO,
// sequencing the line drawer one command at a time with a go/done handshake.
module line_cmd_scheduler
    import line_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_req0_valid,
    input  line_cmd_t              i_req0_cmd,
    output logic                   o_req0_ready,
    input  logic                   i_req1_valid,
    input  line_cmd_t              i_req1_cmd,
    output logic                   o_req1_ready,
    output logic                   o_go,
    input  logic                   i_done,
    output logic [COL_W-1:0]       o_colour,
    output logic [X_W-1:0]         o_X0,
    output logic [Y_W-1:0]         o_Y0,
    output logic [X_W-1:0]         o_X1,
    output logic [Y_W-1:0]         o_Y1,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [CNT_W-1:0]       o_lines_drawn
);
    state_t    state, state_next;
    line_cmd_t head, push_cmd, cur;
    logic      rr, full, empty, push, pop, avail;
    logic      grant0, grant1;

    always_comb begin
        grant0       = i_req0_valid & (!i_req1_valid | !rr);
        grant1       = i_req1_valid & (!i_req0_valid | rr);
        o_req0_ready = grant0 & !full & !i_flush;
        o_req1_ready = grant1 & !full & !i_flush;
        push         = o_req0_ready | o_req1_ready;
        push_cmd     = o_req0_ready ? i_req0_cmd : i_req1_cmd;
    end

    line_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock  (clock),
        .i_reset(i_reset),
        .flush  (i_flush),
        .push   (push),
        .pop    (pop),
        .wdata  (push_cmd),
        .rdata  (head),
        .count  (o_count),
        .full   (full),
        .empty  (empty)
    );

    // avail lags the count by one cycle; empty guards a pop right after a flush
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            rr    <= 1'b0;
            avail <= 1'b0;
            state <= S_IDLE;
        end else begin
            if (push) rr <= o_req0_ready;
            avail <= !empty;
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                pop        = avail & !empty;
                state_next = pop ? S_GO : S_IDLE;
            end
            S_GO:    state_next = i_done ? S_GAP : S_GO;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            cur           <= '0;
            o_go          <= 1'b0;
            o_lines_drawn <= '0;
        end else if (pop) begin
            cur  <= head;
            o_go <= 1'b1;
        end else if (state == S_GO && i_done) begin
            o_go          <= 1'b0;
            o_lines_drawn <= o_lines_drawn + 1'b1;
        end
    end

    assign o_colour = cur.colour;
    assign o_X0     = cur.x0;
    assign o_Y0     = cur.y0;
    assign o_X1     = cur.x1;
    assign o_Y1     = cur.y1;
    assign o_busy   = state != S_IDLE;
endmodule
